// File: rtl/vga_pkg.sv
// vga_pkg: shared types, colour constants and timing presets for the VGA raster engine
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_EXT   = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_SOLID = 2'd3
   } vga_mode_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // control bundle carried alongside each pixel through the alignment delay
   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
      logic frame;
      logic line;
      logic ext;
   } vga_ctrl_t;

   typedef struct packed {
      int   h_active;
      int   h_fp;
      int   h_sync;
      int   h_bp;
      int   v_active;
      int   v_fp;
      int   v_sync;
      int   v_bp;
      logic hs_pol;
      logic vs_pol;
   } vga_timing_t;

   localparam vga_timing_t TIMING_640X480_60 = '{
      h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
      hs_pol: 1'b0, vs_pol: 1'b0
   };

   localparam vga_timing_t TIMING_800X600_60 = '{
      h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
      v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
      hs_pol: 1'b1, vs_pol: 1'b1
   };

   localparam rgb_t BAR_WHITE   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
   localparam rgb_t BAR_YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
   localparam rgb_t BAR_CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
   localparam rgb_t BAR_GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
   localparam rgb_t BAR_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
   localparam rgb_t BAR_RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
   localparam rgb_t BAR_BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
   localparam rgb_t BAR_BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};

   // index 0 is the leftmost bar
   localparam rgb_t [7:0] BAR_RGB = {BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
                                     BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE};

   function automatic logic sync_level(input logic on, input logic pol);
      return on ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth shift register with asynchronous reset to a parametrised value
module vga_delay_line #(
   parameter int           W       = 1,
   parameter int           D       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (D == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
   end else begin : g_sr
      logic [W-1:0] sr [D];
      // shift one stage per clock; every stage resets to the inactive value
      always_ff @(posedge clk or posedge rst)
         if (rst)
            for (int i = 0; i < D; i++) sr[i] <= RST_VAL;
         else begin
            sr[0] <= d;
            for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
         end
      assign q = sr[D-1];
   end

endmodule

// File: rtl/vga_timing_core.sv
// vga_timing_core: parametrised VGA raster engine with latency-aligned pixel requests and test patterns
module vga_timing_core
   import vga_pkg::*;
#(
   parameter int          H_ACTIVE  = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_ACTIVE  = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter logic        HS_POL    = 1'b0,
   parameter logic        VS_POL    = 1'b0,
   parameter int          PIX_LAT   = 2,
   parameter int          CHK_LOG2  = 5,
   parameter logic [23:0] SOLID_RGB = 24'h0000FF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [1:0]                  mode,
   output logic                        pix_req,
   output logic [$clog2(H_ACTIVE)-1:0] pix_x,
   output logic [$clog2(V_ACTIVE)-1:0] pix_y,
   input  logic [23:0]                 pix_rgb,
   output logic [23:0]                 vga_rgb,
   output logic                        vga_hs,
   output logic                        vga_vs,
   output logic                        vga_blank_n,
   output logic                        vga_sync_n,
   output logic                        frame_start,
   output logic                        line_start
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int XW    = $clog2(H_ACTIVE);
   localparam int YW    = $clog2(V_ACTIVE);
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam int BW    = $clog2(BAR_W + 1);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   localparam vga_ctrl_t CTRL_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, act: 1'b0,
                                       frame: 1'b0, line: 1'b0, ext: 1'b0};

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [BW-1:0] bar_run;
   logic [2:0]    bar_idx;
   vga_mode_e     mode_q;
   vga_mode_e     mode_eff;
   logic          h_act;
   logic          v_act;
   logic          hs_on;
   logic          vs_on;
   logic          at_origin;
   logic          chk_dark;
   logic [23:0]   pat;
   vga_ctrl_t     ctrl_s;
   vga_ctrl_t     ctrl_d;
   logic [23:0]   pat_s;
   logic [23:0]   pat_d;

   assign h_act     = h_cnt < H_ACT;
   assign v_act     = v_cnt < V_ACT;
   assign hs_on     = h_cnt >= HS_BEG && h_cnt < HS_END;
   assign vs_on     = v_cnt >= VS_BEG && v_cnt < VS_END;
   assign at_origin = h_cnt == '0 && v_cnt == '0;
   assign mode_eff  = (en && at_origin) ? vga_mode_e'(mode) : mode_q;
   assign chk_dark  = 1'((32'(h_cnt) >> CHK_LOG2) ^ (32'(v_cnt) >> CHK_LOG2));
   assign pat       = mode_eff == MODE_BARS  ? 24'(BAR_RGB[bar_idx]) :
                      mode_eff == MODE_CHECK ? (chk_dark ? 24'h000000 : 24'hFFFFFF) :
                      mode_eff == MODE_SOLID ? SOLID_RGB : 24'h000000;

   // raster position: parked at the origin while disabled, line-then-frame wrap otherwise
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= (!en || h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
         v_cnt <= !en ? '0 : (h_cnt != H_LAST) ? v_cnt : (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end

   // colour-bar run counter tracks the current column; the index saturates on the last bar
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bar_run <= '0;
         bar_idx <= '0;
      end else if (!en || h_cnt == H_LAST) begin
         bar_run <= '0;
         bar_idx <= '0;
      end else if (h_act) begin
         bar_run <= (bar_run == BAR_LAST) ? '0 : bar_run + 1'b1;
         bar_idx <= (bar_run != BAR_LAST || bar_idx == 3'd7) ? bar_idx : bar_idx + 1'b1;
      end

   // pattern mode only changes at the top-left pixel so a frame is never mixed
   always_ff @(posedge clk or posedge rst)
      if (rst)
         mode_q <= MODE_EXT;
      else if (en && at_origin)
         mode_q <= vga_mode_e'(mode);

   // request stage: one cycle behind the counters, forced inactive while disabled
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pix_req <= 1'b0;
         pix_x   <= '0;
         pix_y   <= '0;
         ctrl_s  <= CTRL_IDLE;
         pat_s   <= '0;
      end else begin
         pix_req <= en && h_act && v_act;
         pix_x   <= (en && h_act) ? h_cnt[XW-1:0] : '0;
         pix_y   <= (en && v_act) ? v_cnt[YW-1:0] : '0;
         ctrl_s  <= '{hs: sync_level(en && hs_on, HS_POL), vs: sync_level(en && vs_on, VS_POL),
                      act: en && h_act && v_act, frame: en && at_origin,
                      line: en && h_cnt == '0 && v_act, ext: mode_eff == MODE_EXT};
         pat_s   <= pat;
      end

   vga_delay_line #(
      .W       ($bits(vga_ctrl_t)),
      .D       (PIX_LAT),
      .RST_VAL (CTRL_IDLE)
   ) u_ctrl_dly (
      .clk (clk),
      .rst (rst),
      .d   (ctrl_s),
      .q   (ctrl_d)
   );

   vga_delay_line #(
      .W       (24),
      .D       (PIX_LAT),
      .RST_VAL (24'h000000)
   ) u_pat_dly (
      .clk (clk),
      .rst (rst),
      .d   (pat_s),
      .q   (pat_d)
   );

   // DAC register: external data arrives here exactly PIX_LAT cycles after its request
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vga_rgb     <= '0;
         vga_hs      <= ~HS_POL;
         vga_vs      <= ~VS_POL;
         vga_blank_n <= 1'b0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else begin
         vga_rgb     <= !ctrl_d.act ? 24'h000000 : ctrl_d.ext ? pix_rgb : pat_d;
         vga_hs      <= ctrl_d.hs;
         vga_vs      <= ctrl_d.vs;
         vga_blank_n <= ctrl_d.act;
         frame_start <= ctrl_d.frame;
         line_start  <= ctrl_d.line;
      end

   assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: randomized raster run checked every cycle against an arithmetic reference
module tb_vga_timing_core;

   localparam int   HA = 68, HFP = 4, HSW = 8, HBP = 4;
   localparam int   VA = 12, VFP = 2, VSW = 2, VBP = 3;
   localparam logic HSP = 1'b0, VSP = 1'b1;
   localparam int   LAT = 3, CHK = 2;
   localparam int   HT = HA + HFP + HSW + HBP;
   localparam int   VT = VA + VFP + VSW + VBP;
   localparam int   FR = HT * VT;
   localparam int   L = LAT + 1;
   localparam int   BWID = HA / 8;
   localparam logic [23:0] SOLID = 24'h0000FF;
   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  mode;
   logic        pix_req;
   logic [6:0]  pix_x;
   logic [3:0]  pix_y;
   logic [23:0] pix_rgb;
   logic [23:0] vga_rgb;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_blank_n;
   logic        vga_sync_n;
   logic        frame_start;
   logic        line_start;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit en;
      int h;
      int v;
      int m;
   } rec_t;

   rec_t        hist [0:L];
   int          pos = 0;
   int          frame_mode = 0;
   logic [23:0] src [0:LAT];

   vga_timing_core #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
      .HS_POL (HSP), .VS_POL (VSP), .PIX_LAT (LAT), .CHK_LOG2 (CHK),
      .SOLID_RGB (SOLID)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .pix_req     (pix_req),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_rgb     (pix_rgb),
      .vga_rgb     (vga_rgb),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .vga_sync_n  (vga_sync_n),
      .frame_start (frame_start),
      .line_start  (line_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [23:0] colour(input int m, input int h, input int v);
      if (m == 0) return {8'(h), 8'(v), 8'h00};
      if (m == 1) return BARS[(h / BWID > 7) ? 7 : h / BWID];
      if (m == 2) return (((h >> CHK) ^ (v >> CHK)) & 1) != 0 ? 24'h000000 : 24'hFFFFFF;
      return SOLID;
   endfunction

   // reference: raster position is simply cycles-since-enable modulo the frame length
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= L; i++) hist[i] = '{0, 0, 0, 0};
         pos = 0;
         frame_mode = 0;
      end else begin
         for (int i = L; i > 0; i--) hist[i] = hist[i-1];
         if (en && pos == 0) frame_mode = int'(mode);
         hist[0] = '{en, pos % HT, pos / HT, frame_mode};
         pos = en ? (pos + 1) % FR : 0;
      end
   end

   // external pixel source answering each request LAT cycles later
   always @(negedge clk) begin
      for (int i = LAT; i > 0; i--) src[i] = src[i-1];
      src[0] = pix_req ? {1'b0, pix_x, 4'h0, pix_y, 8'h00} : 24'($urandom);
      pix_rgb = src[LAT];
   end

   always @(negedge clk) begin : cmp
      rec_t o;
      rec_t q;
      bit   act;
      bit   pact;
      o = hist[L];
      q = hist[0];
      act = o.en && o.h < HA && o.v < VA;
      pact = q.en && q.h < HA && q.v < VA;
      chk("blank_n", vga_blank_n, act);
      chk("rgb", vga_rgb, act ? colour(o.m, o.h, o.v) : 24'h0);
      chk("hs", vga_hs, (o.en && o.h >= HA + HFP && o.h < HA + HFP + HSW) ? HSP : !HSP);
      chk("vs", vga_vs, (o.en && o.v >= VA + VFP && o.v < VA + VFP + VSW) ? VSP : !VSP);
      chk("frame_start", frame_start, o.en && o.h == 0 && o.v == 0);
      chk("line_start", line_start, o.en && o.h == 0 && o.v < VA);
      chk("sync_n", vga_sync_n, 0);
      chk("pix_req", pix_req, pact);
      if (pact) begin
         chk("pix_x", pix_x, q.h);
         chk("pix_y", pix_y, q.v);
      end
      if (act && o.m == 1 && o.v == 0 && o.h == 7) chk("bar0_last_white", vga_rgb, 24'hFFFFFF);
      if (act && o.m == 1 && o.v == 0 && o.h == 8) chk("bar1_first_yellow", vga_rgb, 24'hFFFF00);
      if (act && o.m == 1 && o.v == 0 && o.h == 55) chk("bar6_blue", vga_rgb, 24'h0000FF);
      if (act && o.m == 1 && o.v == 0 && o.h == 67) chk("bar_remainder_black", vga_rgb, 24'h000000);
      if (act && o.m == 2 && o.v == 0 && o.h == 0) chk("chk_origin_white", vga_rgb, 24'hFFFFFF);
      if (act && o.m == 2 && o.v == 0 && o.h == 4) chk("chk_4_0_black", vga_rgb, 24'h000000);
      if (act && o.m == 0 && o.v == 0 && o.h == 0) chk("ext_first_pixel", vga_rgb, 24'h000000);
      if (act && o.m == 0 && o.v == 2 && o.h == 5) chk("ext_5_2", vga_rgb, 24'h050200);
      if (o.en && o.v == 0 && o.h == HA + HFP) chk("hs_first_low", vga_hs, 0);
      if (o.en && o.v == 0 && o.h == HA + HFP - 1) chk("hs_high_before", vga_hs, 1);
   end

   task automatic wait_fs(output int n, input int lim);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < lim);
      if (!frame_start) begin
         checks++;
         errors++;
         $display("FAIL wait_frame_start timeout after %0d cycles", n);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_rgb"}, vga_rgb, 0);
      chk({tag, "_blank_n"}, vga_blank_n, 0);
      chk({tag, "_hs"}, vga_hs, !HSP);
      chk({tag, "_vs"}, vga_vs, !VSP);
      chk({tag, "_frame_start"}, frame_start, 0);
      chk({tag, "_line_start"}, line_start, 0);
      chk({tag, "_pix_req"}, pix_req, 0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      en = 1'b0;
      mode = 2'd1;
      pix_rgb = '0;
      for (int i = 0; i <= LAT; i++) src[i] = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      chk("reset_pix_x", pix_x, 0);
      chk("reset_pix_y", pix_y, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      en = 1'b1;
      wait_fs(n, 50);
      chk("fs_after_en", n, LAT + 2);
      wait_fs(n, FR + 10);
      chk("frame_period", n, FR);
      repeat (5 * HT) @(negedge clk);
      mode = 2'd2;
      wait_fs(n, FR + 10);
      wait_fs(n, FR + 10);
      chk("frame_period_checker", n, FR);
      mode = 2'd0;
      wait_fs(n, FR + 10);
      wait_fs(n, FR + 10);
      mode = 2'd3;
      wait_fs(n, FR + 10);
      repeat (HT + 10) @(negedge clk);
      en = 1'b0;
      repeat (LAT + 2) @(negedge clk);
      check_idle("en_drop");
      repeat (7) @(negedge clk);
      en = 1'b1;
      wait_fs(n, 50);
      chk("fs_after_reenable", n, LAT + 2);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(pix_req && pix_x == 7'd4) && n < 4 * HT);
      chk("found_h5", pix_req && pix_x == 7'd4, 1);
      #2 rst = 1'b1;
      #1;
      check_idle("mid_line_rst");
      chk("mid_line_rst_pix_x", pix_x, 0);
      chk("mid_line_rst_pix_y", pix_y, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_fs(n, 50);
      chk("fs_after_rst", n, LAT + 2);
      for (int it = 0; it < 16; it++) begin
         mode = 2'($urandom_range(0, 3));
         repeat ($urandom_range(20, 1500)) @(negedge clk);
         case ($urandom_range(0, 3))
            0: begin
               en = 1'b0;
               repeat ($urandom_range(1, 200)) @(negedge clk);
               en = 1'b1;
            end
            1: begin
               @(posedge clk);
               #2 rst = 1'b1;
               #1;
               chk("rand_rst_rgb", vga_rgb, 0);
               chk("rand_rst_blank_n", vga_blank_n, 0);
               chk("rand_rst_pix_req", pix_req, 0);
               @(negedge clk);
               rst = 1'b0;
            end
            default: ;
         endcase
      end
      repeat (FR) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
